// File: rtl/date_pkg.sv
// date_pkg: shared widths, month constants and days-in-month function for the date counter
package date_pkg;
  localparam int DAY_W = 5;
  localparam int MON_W = 4;
  localparam logic [MON_W-1:0] MON_JAN = 4'd1;
  localparam logic [MON_W-1:0] MON_FEB = 4'd2;
  localparam logic [MON_W-1:0] MON_DEC = 4'd12;
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m, input logic leap);
    return m == MON_FEB ? (leap ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
endpackage

// File: rtl/date_dim_lut.sv
// date_dim_lut: combinational month/leap to days-in-month lookup
module date_dim_lut
  import date_pkg::*;
(
  input  logic [MON_W-1:0] month,
  input  logic             leap,
  output logic [DAY_W-1:0] dim
);
  assign dim = days_in_month(month, leap);
endmodule

// File: rtl/date_day_month_counter.sv
// date_day_month_counter: calendar day/month counter; DATE_MANUAL_CASCADE_EN makes manual day steps cascade into month/year
module date_day_month_counter
  import date_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             day_tick,
  input  logic             day_inc_manual,
  input  logic             day_dec_manual,
  input  logic             mon_inc_manual,
  input  logic             mon_dec_manual,
  input  logic             leap,
  output logic [DAY_W-1:0] day,
  output logic [MON_W-1:0] month,
  output logic             year_carry,
  output logic             year_borrow
);
`ifdef DATE_MANUAL_CASCADE_EN
  localparam logic CASC = 1'b1;
`else
  localparam logic CASC = 1'b0;
`endif
  logic [DAY_W-1:0] day_q, day_d, dim_cur, dim_new;
  logic [MON_W-1:0] month_q, month_d;
  logic carry_q, carry_d, borrow_q, borrow_d;
  logic d_up, up, dn, m_up, m_dn, casc_up, wrap_up, wrap_dn, fwd, bwd;
  date_dim_lut u_dim_cur (.month(month_q), .leap(leap), .dim(dim_cur));
  date_dim_lut u_dim_new (.month(month_d), .leap(leap), .dim(dim_new));
  always_comb begin
    d_up     = day_tick | day_inc_manual;
    up       = d_up & ~day_dec_manual;
    dn       = day_dec_manual & ~d_up;
    m_up     = ~(up | dn) & mon_inc_manual & ~mon_dec_manual;
    m_dn     = ~(up | dn) & mon_dec_manual & ~mon_inc_manual;
    casc_up  = day_tick | (CASC & day_inc_manual);
    wrap_up  = day_q >= dim_cur;
    wrap_dn  = day_q <= DAY_W'(1);
    fwd      = (up & casc_up & wrap_up) | m_up;
    bwd      = (dn & CASC & wrap_dn) | m_dn;
    month_d  = fwd ? (month_q == MON_DEC ? MON_JAN : month_q + 1'b1) :
               bwd ? (month_q == MON_JAN ? MON_DEC : month_q - 1'b1) : month_q;
    // dim_new follows month_d, so it also serves the in-month wrap and the idle clamp
    day_d    = up ? (wrap_up ? DAY_W'(1) : day_q + 1'b1) :
               dn ? (wrap_dn ? dim_new : day_q - 1'b1) :
               (day_q > dim_new ? dim_new : day_q);
    carry_d  = up & casc_up & wrap_up & (month_q == MON_DEC);
    borrow_d = dn & CASC & wrap_dn & (month_q == MON_JAN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      day_q    <= DAY_W'(1);
      month_q  <= MON_JAN;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      day_q    <= day_d;
      month_q  <= month_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end
  assign day         = day_q;
  assign month       = month_q;
  assign year_carry  = carry_q;
  assign year_borrow = borrow_q;
endmodule

// File: doc/date_day_month_counter.md
# date_day_month_counter

Calendar day/month counter feeding the year counter of the clock-calendar datapath. Counts day 1..days-in-month and month 1..12, using the `leap` flag from the year counter to size February. Emits a one-cycle `year_carry` pulse on the 31 Dec → 1 Jan rollover, which drives the year counter's auto-increment input. Accepts manual day/month adjust pulses from the set-mode UI.

## Interface
Parameters:
- none; all widths and constants come from the shared package.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `day_tick`  in  1  carry from the hour counter (23→0); one day forward
- `day_inc_manual`  in  1  manual day +1
- `day_dec_manual`  in  1  manual day −1
- `mon_inc_manual`  in  1  manual month +1
- `mon_dec_manual`  in  1  manual month −1
- `leap`  in  1  current year is a leap year (from the year counter)
- `day`  out  5  current day, 1..31
- `month`  out  4  current month, 1..12
- `year_carry`  out  1  registered one-cycle pulse: year +1
- `year_borrow`  out  1  registered one-cycle pulse: year −1 (only driven with the macro; see Configuration)

## Operation
- `dim` = days in month: 31/30 per calendar; February is 29 if `leap`, else 28.
- Net commands:
  - `d_up = day_tick | day_inc_manual`
  - `d_dn = day_dec_manual`
  - `m_up = mon_inc_manual`
  - `m_dn = mon_dec_manual`
- Exactly one update per cycle, in this priority order:
  1. **Day step.** Applies if exactly one of `d_up`/`d_dn` is set. Month commands are ignored that cycle. If `d_up` and `d_dn` are both set, nothing happens; month commands are still considered.
  2. **Month step.** Applies if no day step and exactly one of `m_up`/`m_dn` is set. If both are set, nothing happens.
  3. **Clamp.** Applies if no step: if `day > dim`, load `day <= dim`.
- Day up (auto, i.e. `day_tick`):
  - If `day >= dim`: `day <= 1`, month advances.
  - If month was 12, `month <= 1` and `year_carry` pulses.
- Day down, and day up from a manual command: behaviour is set by the macro (see Configuration).
- Month step:
  - Up wraps 12 → 1; down wraps 1 → 12. Never touches the year.
  - In the same cycle, `day <= min(day, dim(new_month, leap))`.
- `leap` may change at any time (year update lands one cycle after `year_carry`). The clamp rule repairs Feb 29 → Feb 28 on the next idle cycle.
- Arithmetic:
  - Unsigned compares on 5-bit `day` and 4-bit `month`.
  - No out-of-range value (`day` 0 or >31, `month` 0 or >12) is ever produced.

## Timing
- Reset: `day = 1`, `month = 1`, `year_carry = 0`, `year_borrow = 0`. Reset overrides every command in the same edge.
- `day`/`month` update on the edge that samples the command; latency is 1 cycle.
- `year_carry`/`year_borrow` go high on the same edge as the 1 Jan / 31 Dec load. They last exactly one cycle and are cleared on the next edge.
- The year counter samples the pulse on the following edge, so `leap` is valid for the new year two edges after the wrapping command.
- Back-to-back `day_tick` on consecutive cycles is supported. Each one advances exactly one day.

## Configuration
- Macro: `DATE_MANUAL_CASCADE_EN`.
- **Defined:**
  - Manual day inc/dec cascades exactly like auto.
  - Inc: `dim` → 1 advances the month; 31 Dec → 1 Jan pulses `year_carry`.
  - Dec: from day 1, load the previous month and `day <= dim(prev_month, leap)`.
  - Dec on 1 Jan: load 31 Dec and pulse `year_borrow`.
- **Undefined:**
  - Manual day inc/dec wraps within the current month only: inc `dim` → 1, dec 1 → `dim`. Month and year are unchanged.
  - `year_borrow` is tied 0.

## Structure
- Shared package `date_pkg` holds:
  - width constants `DAY_W = 5`, `MON_W = 4`
  - month constants `MON_JAN = 1`, `MON_FEB = 2`, `MON_DEC = 12`
  - a `days_in_month(month, leap)` function
- One sub-module, `date_dim_lut`: combinational `month, leap` → `dim`. It is instantiated twice, once for the current month and once for the candidate new month.

## Test plan
- **Reset:** assert `rst` mid-count at 15 Jul → next edge: day=1, month=1, no pulses.
- **Leap February:** `leap=1`, 28 Feb, `day_tick` ×2 → 29 Feb, then 1 Mar. `leap=0`, 28 Feb, `day_tick` → 1 Mar.
- **Year rollover:** 31 Dec, `day_tick` → 1 Jan with `year_carry` = 1 for exactly one cycle. Year-counter model increments once; `leap` then follows it.
- **Month clamp:** 31 Jan, `mon_inc_manual` → 29 Feb (`leap=1`). Then drop `leap` with no commands → next edge 28 Feb.
- **Simultaneous commands:**
  - 10 May, `day_inc_manual` + `day_dec_manual` + `mon_inc_manual` → 10 Jun.
  - `day_tick` + `mon_dec_manual` → 11 May.
- **Macro:** 1 Jan, `day_dec_manual`:
  - defined → 31 Dec with `year_borrow` pulse
  - undefined → 31 Jan, no pulse
